// File: rtl/lc3_execute_stage_if.sv
// Execute-stage bus: operands, control and bypass selects in, registered
// results toward memory/writeback out.
interface lc3_execute_stage_if #(
    parameter int DATA_W = 16
);
    logic              enable_execute;
    logic [5:0]        E_control;
    logic              bypass_alu_1;
    logic              bypass_alu_2;
    logic              bypass_mem_1;
    logic              bypass_mem_2;
    logic [DATA_W-1:0] VSR1;
    logic [DATA_W-1:0] VSR2;
    logic [DATA_W-1:0] Mem_Bypass_Val;
    logic [DATA_W-1:0] IR;
    logic [DATA_W-1:0] npc_in;
    logic              Mem_Control_in;
    logic [1:0]        W_Control_in;

    logic [DATA_W-1:0] aluout;
    logic [DATA_W-1:0] pcout;
    logic [2:0]        dr;
    logic [2:0]        NZP;
    logic [DATA_W-1:0] M_Data;
    logic [DATA_W-1:0] IR_Exec;
    logic              Mem_Control_out;
    logic [1:0]        W_Control_out;
    logic [2:0]        sr1;
    logic [2:0]        sr2;

    modport master (
        output enable_execute, E_control, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, VSR1, VSR2, Mem_Bypass_Val,
               IR, npc_in, Mem_Control_in, W_Control_in,
        input  aluout, pcout, dr, NZP, M_Data, IR_Exec, Mem_Control_out,
               W_Control_out, sr1, sr2
    );

    modport slave (
        input  enable_execute, E_control, bypass_alu_1, bypass_alu_2,
               bypass_mem_1, bypass_mem_2, VSR1, VSR2, Mem_Bypass_Val,
               IR, npc_in, Mem_Control_in, W_Control_in,
        output aluout, pcout, dr, NZP, M_Data, IR_Exec, Mem_Control_out,
               W_Control_out, sr1, sr2
    );
endinterface

// File: rtl/lc3_execute_stage.sv
// LC3 execute stage: operand forwarding, ALU, address generation and the
// enable/reset-gated register bank feeding memory and writeback.
module lc3_execute_stage #(
    parameter int DATA_W          = 16,
    parameter bit ALU_BYPASS_PRIO = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset,
    lc3_execute_stage_if.slave   ex
);
    typedef enum logic [3:0] {
        OP_BR  = 4'b0000,
        OP_ADD = 4'b0001,
        OP_ST  = 4'b0011,
        OP_AND = 4'b0101,
        OP_STR = 4'b0111,
        OP_NOT = 4'b1001,
        OP_STI = 4'b1011,
        OP_JMP = 4'b1100
    } opcode_e;

    logic [3:0]        opcode;
    logic [1:0]        alu_control;
    logic [1:0]        pcselect1;
    logic              pcselect2;
    logic              op2select;
    logic [DATA_W-1:0] op1;
    logic [DATA_W-1:0] src2;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] offset;
    logic [DATA_W-1:0] base;
    logic [DATA_W-1:0] address;
    logic [2:0]        nzp_next;
    logic              is_alu_op;

    assign opcode      = ex.IR[15:12];
    assign alu_control = ex.E_control[5:4];
    assign pcselect1   = ex.E_control[3:2];
    assign pcselect2   = ex.E_control[1];
    assign op2select   = ex.E_control[0];

    assign ex.sr1 = ex.IR[8:6];
    assign ex.sr2 = (opcode inside {OP_ST, OP_STR, OP_STI}) ? ex.IR[11:9] : ex.IR[2:0];

    // Forwarding reads the registered aluout, closing the loop through the bank.
    always_comb begin
        op1 = ex.VSR1;
        if (ex.bypass_alu_1 && ex.bypass_mem_1)
            op1 = ALU_BYPASS_PRIO ? ex.aluout : ex.Mem_Bypass_Val;
        else if (ex.bypass_alu_1)
            op1 = ex.aluout;
        else if (ex.bypass_mem_1)
            op1 = ex.Mem_Bypass_Val;
    end

    always_comb begin
        src2 = ex.VSR2;
        if (ex.bypass_alu_2 && ex.bypass_mem_2)
            src2 = ALU_BYPASS_PRIO ? ex.aluout : ex.Mem_Bypass_Val;
        else if (ex.bypass_alu_2)
            src2 = ex.aluout;
        else if (ex.bypass_mem_2)
            src2 = ex.Mem_Bypass_Val;
    end

    assign alu_b = op2select ? src2 : {{(DATA_W-5){ex.IR[4]}}, ex.IR[4:0]};

    always_comb begin
        alu_res = '0;
        case (alu_control)
            2'b00:   alu_res = op1 + alu_b;
            2'b01:   alu_res = op1 & alu_b;
            2'b10:   alu_res = ~op1;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        offset = '0;
        case (pcselect1)
            2'b00:   offset = {{(DATA_W-11){ex.IR[10]}}, ex.IR[10:0]};
            2'b01:   offset = {{(DATA_W-9){ex.IR[8]}}, ex.IR[8:0]};
            2'b10:   offset = {{(DATA_W-6){ex.IR[5]}}, ex.IR[5:0]};
            default: offset = '0;
        endcase
    end

    assign base    = pcselect2 ? ex.npc_in : op1;
    assign address = base + offset;

    assign is_alu_op = (opcode inside {OP_ADD, OP_AND, OP_NOT});

    always_comb begin
        nzp_next = '0;
        if (opcode == OP_BR)
            nzp_next = ex.IR[11:9];
        else if (opcode == OP_JMP)
            nzp_next = '1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex.aluout          <= '0;
            ex.pcout           <= '0;
            ex.dr              <= '0;
            ex.NZP             <= '0;
            ex.M_Data          <= '0;
            ex.IR_Exec         <= '0;
            ex.Mem_Control_out <= '0;
            ex.W_Control_out   <= '0;
        end else if (ex.enable_execute) begin
            ex.aluout          <= is_alu_op ? alu_res : address;
            ex.pcout           <= address;
            ex.dr              <= ex.IR[11:9];
            ex.NZP             <= nzp_next;
            ex.M_Data          <= src2;
            ex.IR_Exec         <= ex.IR;
            ex.Mem_Control_out <= ex.Mem_Control_in;
            ex.W_Control_out   <= ex.W_Control_in;
        end
    end
endmodule

// File: tb/tb_lc3_execute_stage.sv
// Scoreboard bench for lc3_execute_stage: both bypass priorities run side by
// side on identical stimulus against a behavioural model.
module tb_lc3_execute_stage;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic        s_en;
    logic [5:0]  s_ec;
    logic        s_ba1, s_ba2, s_bm1, s_bm2;
    logic [15:0] s_vsr1, s_vsr2, s_mbv, s_ir, s_npc;
    logic        s_mc;
    logic [1:0]  s_wc;

    lc3_execute_stage_if #(.DATA_W(16)) ifa ();
    lc3_execute_stage_if #(.DATA_W(16)) ifb ();

    always_comb begin
        ifa.enable_execute = s_en;   ifb.enable_execute = s_en;
        ifa.E_control      = s_ec;   ifb.E_control      = s_ec;
        ifa.bypass_alu_1   = s_ba1;  ifb.bypass_alu_1   = s_ba1;
        ifa.bypass_alu_2   = s_ba2;  ifb.bypass_alu_2   = s_ba2;
        ifa.bypass_mem_1   = s_bm1;  ifb.bypass_mem_1   = s_bm1;
        ifa.bypass_mem_2   = s_bm2;  ifb.bypass_mem_2   = s_bm2;
        ifa.VSR1           = s_vsr1; ifb.VSR1           = s_vsr1;
        ifa.VSR2           = s_vsr2; ifb.VSR2           = s_vsr2;
        ifa.Mem_Bypass_Val = s_mbv;  ifb.Mem_Bypass_Val = s_mbv;
        ifa.IR             = s_ir;   ifb.IR             = s_ir;
        ifa.npc_in         = s_npc;  ifb.npc_in         = s_npc;
        ifa.Mem_Control_in = s_mc;   ifb.Mem_Control_in = s_mc;
        ifa.W_Control_in   = s_wc;   ifb.W_Control_in   = s_wc;
    end

    lc3_execute_stage #(.DATA_W(16), .ALU_BYPASS_PRIO(1'b1)) dut_a (
        .clock(clock), .reset(reset), .ex(ifa)
    );
    lc3_execute_stage #(.DATA_W(16), .ALU_BYPASS_PRIO(1'b0)) dut_b (
        .clock(clock), .reset(reset), .ex(ifb)
    );

    typedef struct {
        logic [15:0] aluout, pcout, m_data, ir_exec;
        logic [2:0]  dr, nzp, sr1, sr2;
        logic        mc;
        logic [1:0]  wc;
        bit          has_gold;
        logic [15:0] gold_alu;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    exp_t st_a, st_b;
    int checks = 0;
    int errors = 0;

    function automatic logic [15:0] pick(input bit a, input bit m, input logic [15:0] av,
                                         input logic [15:0] mv, input logic [15:0] rv,
                                         input bit prio);
        if (a && m) return prio ? av : mv;
        if (a) return av;
        if (m) return mv;
        return rv;
    endfunction

    // Next visible state of a stage given the present bench inputs.
    function automatic exp_t model(input exp_t prev, input bit prio);
        exp_t n;
        logic [15:0] op1, src2, alu_b, base, alu_v, addr;
        logic [3:0] opc;
        int off, sum;
        n = prev;
        opc = s_ir[15:12];
        n.has_gold = 1'b0;
        n.gold_alu = '0;
        n.sr1 = s_ir[8:6];
        n.sr2 = (opc == 4'h3 || opc == 4'h7 || opc == 4'hB) ? s_ir[11:9] : s_ir[2:0];
        if (reset) begin
            n.aluout = '0; n.pcout = '0; n.m_data = '0; n.ir_exec = '0;
            n.dr = '0; n.nzp = '0; n.mc = 1'b0; n.wc = '0;
        end else if (s_en) begin
            op1   = pick(s_ba1, s_bm1, prev.aluout, s_mbv, s_vsr1, prio);
            src2  = pick(s_ba2, s_bm2, prev.aluout, s_mbv, s_vsr2, prio);
            alu_b = s_ec[0] ? src2 : 16'(32'($signed(s_ir[4:0])));
            case (s_ec[5:4])
                2'd0: alu_v = 16'((int'(op1) + int'(alu_b)) % 65536);
                2'd1: alu_v = op1 & alu_b;
                2'd2: alu_v = 16'(65535 - int'(op1));
                default: alu_v = 16'd0;
            endcase
            case (s_ec[3:2])
                2'd0: off = int'($signed(s_ir[10:0]));
                2'd1: off = int'($signed(s_ir[8:0]));
                2'd2: off = int'($signed(s_ir[5:0]));
                default: off = 0;
            endcase
            base = s_ec[1] ? s_npc : op1;
            sum  = (int'(base) + off + 65536) % 65536;
            addr = 16'(sum);
            n.aluout  = (opc == 4'h1 || opc == 4'h5 || opc == 4'h9) ? alu_v : addr;
            n.pcout   = addr;
            n.dr      = s_ir[11:9];
            n.nzp     = (opc == 4'h0) ? s_ir[11:9] : (opc == 4'hC) ? 3'b111 : 3'b000;
            n.m_data  = src2;
            n.ir_exec = s_ir;
            n.mc      = s_mc;
            n.wc      = s_wc;
        end
        return n;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: outputs are presented one cycle after each issued stimulus.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (qa.size() > 0) begin
                e = qa.pop_front();
                chk("A.aluout", ifa.aluout, e.aluout);
                chk("A.pcout", ifa.pcout, e.pcout);
                chk("A.dr", 16'(ifa.dr), 16'(e.dr));
                chk("A.NZP", 16'(ifa.NZP), 16'(e.nzp));
                chk("A.M_Data", ifa.M_Data, e.m_data);
                chk("A.IR_Exec", ifa.IR_Exec, e.ir_exec);
                chk("A.Mem_Control_out", 16'(ifa.Mem_Control_out), 16'(e.mc));
                chk("A.W_Control_out", 16'(ifa.W_Control_out), 16'(e.wc));
                chk("A.sr1", 16'(ifa.sr1), 16'(e.sr1));
                chk("A.sr2", 16'(ifa.sr2), 16'(e.sr2));
                if (e.has_gold) chk("A.aluout_directed", ifa.aluout, e.gold_alu);
            end
            if (qb.size() > 0) begin
                e = qb.pop_front();
                chk("B.aluout", ifb.aluout, e.aluout);
                chk("B.pcout", ifb.pcout, e.pcout);
                chk("B.dr", 16'(ifb.dr), 16'(e.dr));
                chk("B.NZP", 16'(ifb.NZP), 16'(e.nzp));
                chk("B.M_Data", ifb.M_Data, e.m_data);
                chk("B.IR_Exec", ifb.IR_Exec, e.ir_exec);
                chk("B.Mem_Control_out", 16'(ifb.Mem_Control_out), 16'(e.mc));
                chk("B.W_Control_out", 16'(ifb.W_Control_out), 16'(e.wc));
                chk("B.sr1", 16'(ifb.sr1), 16'(e.sr1));
                chk("B.sr2", 16'(ifb.sr2), 16'(e.sr2));
                if (e.has_gold) chk("B.aluout_directed", ifb.aluout, e.gold_alu);
            end
        end
    end

    // Issue the current inputs for one cycle; called on a negedge, returns on the next.
    task automatic step(input bit has_gold, input logic [15:0] ga, input logic [15:0] gb);
        exp_t ea, eb;
        st_a = model(st_a, 1'b1);
        st_b = model(st_b, 1'b0);
        ea = st_a; eb = st_b;
        ea.has_gold = has_gold; ea.gold_alu = ga;
        eb.has_gold = has_gold; eb.gold_alu = gb;
        qa.push_back(ea);
        qb.push_back(eb);
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic rand_inputs();
        s_ec   = 6'($urandom);
        s_ba1  = 1'($urandom); s_ba2 = 1'($urandom);
        s_bm1  = 1'($urandom); s_bm2 = 1'($urandom);
        s_vsr1 = 16'($urandom); s_vsr2 = 16'($urandom);
        s_mbv  = 16'($urandom); s_ir   = 16'($urandom);
        s_npc  = 16'($urandom); s_mc   = 1'($urandom);
        s_wc   = 2'($urandom);
    endtask

    task automatic plain(input logic [15:0] ir, input logic [5:0] ec);
        s_en = 1'b1; reset = 1'b0; s_ir = ir; s_ec = ec;
        s_ba1 = 0; s_ba2 = 0; s_bm1 = 0; s_bm2 = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        st_a = '{default: '0};
        st_b = '{default: '0};
        reset = 1'b1; s_en = 1'b1;
        rand_inputs();
        @(negedge clock);

        step(1'b1, 16'h0000, 16'h0000);
        rand_inputs();
        step(1'b1, 16'h0000, 16'h0000);
        reset = 1'b0; s_en = 1'b0;
        rand_inputs();
        step(1'b1, 16'h0000, 16'h0000);
        step(1'b1, 16'h0000, 16'h0000);

        // ADD reg-reg, signed overflow wraps silently
        plain(16'h1283, 6'b000001); s_vsr1 = 16'h7FFF; s_vsr2 = 16'h0001;
        step(1'b1, 16'h8000, 16'h8000);
        // AND imm5 (-4), NOT
        plain(16'h5A7C, 6'b010000); s_vsr1 = 16'h00FF;
        step(1'b1, 16'h00FC, 16'h00FC);
        plain(16'h927F, 6'b100000); s_vsr1 = 16'h0F0F;
        step(1'b1, 16'hF0F0, 16'hF0F0);

        // Bypass priority: seed aluout=0x1234, then both bypasses on op1
        plain(16'h1060, 6'b000000); s_vsr1 = 16'h1234;
        step(1'b1, 16'h1234, 16'h1234);
        plain(16'h1060, 6'b000000); s_mbv = 16'h5678; s_vsr1 = 16'h0BAD;
        s_ba1 = 1'b1; s_bm1 = 1'b1;
        step(1'b1, 16'h1234, 16'h5678);
        plain(16'h1060, 6'b000000); s_mbv = 16'h5678; s_bm1 = 1'b1;
        step(1'b1, 16'h5678, 16'h5678);

        // Branch target wrap and JMP
        plain(16'h0E01, 6'b000110); s_npc = 16'hFFFF;
        step(1'b1, 16'h0000, 16'h0000);
        plain(16'hC1C0, 6'b001100); s_vsr1 = 16'h3000;
        step(1'b1, 16'h3000, 16'h3000);

        // Store data then hold with enable low
        plain(16'h7A45, 6'b001000); s_vsr2 = 16'hBEEF; s_vsr1 = 16'h4000;
        step(1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            rand_inputs(); s_en = 1'b0; reset = 1'b0;
            step(1'b0, 16'h0000, 16'h0000);
        end
        rand_inputs(); s_en = 1'b1; reset = 1'b1;
        step(1'b1, 16'h0000, 16'h0000);
        reset = 1'b0;

        // Randomized phase with frequent forwarding chains
        for (int i = 0; i < 400; i++) begin
            rand_inputs();
            s_en  = ($urandom_range(0, 9) < 8);
            reset = ($urandom_range(0, 49) == 0);
            step(1'b0, 16'h0000, 16'h0000);
        end

        @(posedge clock);
        #2;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d/%0d pending required=0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/lc3_execute_stage.md
Name: lc3_execute_stage

Overview:
- Execute stage of the LC3 pipelined core; sole consumer of the execute_in bus (enable_execute, E_control, bypass_*, VSR1/VSR2, Mem_Bypass_Val, IR, npc_in, Mem_Control_in, W_Control_in).
- Performs ALU operations, effective-address / branch-target computation and operand forwarding.
- Registers results toward the memory-access and writeback stages; observed by the execute_out agent.

Parameters:
- DATA_W, 16, datapath width; only 16 is supported; controls all data buses.
- ALU_BYPASS_PRIO, 1, when 1 the ALU bypass wins over the memory bypass if both are asserted for the same operand; when 0 the memory bypass wins.

Ports:
- clock  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- enable_execute  input  1  stage advance; registers update only when high
- E_control  input  6  {alu_control[5:4], pcselect1[3:2], pcselect2[1], op2select[0]}
- bypass_alu_1  input  1  operand1 taken from this stage's registered aluout
- bypass_alu_2  input  1  operand2 taken from registered aluout
- bypass_mem_1  input  1  operand1 taken from Mem_Bypass_Val
- bypass_mem_2  input  1  operand2 taken from Mem_Bypass_Val
- VSR1  input  16  register-file value of sr1
- VSR2  input  16  register-file value of sr2
- Mem_Bypass_Val  input  16  forwarded memory-stage data
- IR  input  16  instruction in execute
- npc_in  input  16  PC+1 of the instruction
- Mem_Control_in  input  1  memory-stage control, passed through
- W_Control_in  input  2  writeback control, passed through
- aluout  output  16  registered ALU result or effective address
- pcout  output  16  registered address/branch target
- dr  output  3  registered destination register, IR[11:9]
- NZP  output  3  registered branch condition mask
- M_Data  output  16  registered store data (resolved operand2)
- IR_Exec  output  16  registered copy of IR
- Mem_Control_out  output  1  registered Mem_Control_in
- W_Control_out  output  2  registered W_Control_in
- sr1  output  3  combinational IR[8:6]
- sr2  output  3  combinational; IR[11:9] for ST/STR/STI (opcodes 0011/0111/1011), else IR[2:0]

Behaviour:
- Reset: synchronous. On a rising edge with reset=1, all registered outputs go to 0, overriding enable_execute. sr1/sr2 stay combinational.
- Latency: one cycle. Inputs sampled at edge N with enable_execute=1 appear on outputs after edge N.
- enable_execute=0: every registered output holds its value. aluout also holds, so forwarding sources remain stable.
- Operand1 (op1):
  - bypass_alu_1 and bypass_mem_1 both high: the winner is set by ALU_BYPASS_PRIO.
  - only bypass_alu_1: aluout.
  - only bypass_mem_1: Mem_Bypass_Val.
  - neither: VSR1.
- Operand2 source (src2): same rule using bypass_alu_2, bypass_mem_2 and VSR2.
- ALU second input: src2 when op2select=1, else sext(IR[4:0]).
- ALU operation (alu_control):
  - 00: op1 + aluB, modulo 2^16, no carry out.
  - 01: op1 & aluB.
  - 10: ~op1.
  - 11: reserved; result 0.
- Address offset (pcselect1):
  - 00: sext(IR[10:0])
  - 01: sext(IR[8:0])
  - 10: sext(IR[5:0])
  - 11: 0
- Address base: npc_in when pcselect2=1, else op1. address = base + offset, modulo 2^16; wrap-around (0xFFFF+1 = 0x0000) is legal.
- aluout: ALU result when IR[15:12] is ADD(0001), AND(0101) or NOT(1001); otherwise the address.
- pcout: always the address.
- M_Data: src2, so the resolved and bypassed store value.
- NZP: IR[11:9] for BR(0000); 3'b111 for JMP(1100); 3'b000 otherwise.
- dr: IR[11:9] for all opcodes.
- Pass-through registers: IR_Exec, Mem_Control_out and W_Control_out capture their inputs.
- Simultaneous reset and enable: reset wins.
- Bypass while enable is low: no register update, so there is no effect.
- Back-to-back ALU-bypass chains are legal every cycle.
- Structure: no FSM beyond the enable/reset-gated pipeline register bank. The bank is the sequential element; forwarding closes a loop through aluout.

Test Plan:
- Reset: assert reset 2 cycles with arbitrary inputs -> all registered outputs 0; deassert, enable=0 -> outputs stay 0.
- ADD reg-reg: IR=0x1283 (R1=R2+R3), E_control=6'b000001, VSR1=0x7FFF, VSR2=0x0001, enable=1 -> next cycle aluout=0x8000, dr=1, sr1=2, sr2=3, NZP=0.
- AND imm5: IR=0x5A7C (imm -4), E_control=6'b010000, VSR1=0x00FF -> aluout=0x00FC. NOT with E_control=6'b100000, VSR1=0x0F0F -> aluout=0xF0F0.
- Bypass priority: prior aluout=0x1234, Mem_Bypass_Val=0x5678, bypass_alu_1=bypass_mem_1=1, ADD imm5 0 -> aluout=0x1234 with ALU_BYPASS_PRIO=1, 0x5678 with ALU_BYPASS_PRIO=0. Mem bypass only -> 0x5678.
- Branch wrap: IR=0x0E01 (BRnzp +1), npc_in=0xFFFF, E_control=6'b000110 -> pcout=0x0000, aluout=0x0000, NZP=3'b111. JMP IR=0xC1C0, pcselect1=11, pcselect2=0, VSR1=0x3000 -> pcout=0x3000, NZP=3'b111.
- Enable hold / store data: STR IR=0x7A45, VSR2=0xBEEF, enable=1 -> M_Data=0xBEEF, sr2=5. Drop enable, change all inputs for 3 cycles -> every registered output unchanged. Reset on a cycle with enable=1 -> outputs 0.
